// File: rtl/gpio_input_conditioner.sv
// Pin input conditioner: per-bit synchronizer, programmable debounce and edge pulses
// feeding the GPIO core's gpio_io_i. Bits are independent lanes of gpio_ic_bit.

module gpio_ic_bit #(
   parameter int SYNC_STAGES    = 2,
   parameter int DEBOUNCE_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      pin_i,
   input  logic [DEBOUNCE_WIDTH-1:0] thresh_i,
   input  logic                      bypass_i,
   output logic                      level_o,
   output logic                      rise_o,
   output logic                      fall_o
);
   logic [SYNC_STAGES-1:0]    sync_q;
   logic                      sync;
   logic                      stable_q, stable_d;
   logic                      rise_q, rise_d;
   logic                      fall_q, fall_d;
   logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;

   // Only the first flop of this chain ever samples the raw pin.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
   end

   assign sync = sync_q[SYNC_STAGES-1];

   // >= rather than == so a threshold lowered mid-count accepts next cycle,
   // and the counter stops at the threshold so it can never wrap.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (bypass_i) begin
         stable_d = sync;
      end else if (sync != stable_q) begin
         if (cnt_q >= thresh_i) stable_d = sync;
         else                   cnt_d    = cnt_q + DEBOUNCE_WIDTH'(1);
      end
      rise_d = ~stable_q &  stable_d;
      fall_d =  stable_q & ~stable_d;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stable_q <= 1'b0;
         cnt_q    <= '0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   assign level_o = stable_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
endmodule

module gpio_input_conditioner #(
   parameter int GPIO_WIDTH     = 32,
   parameter int SYNC_STAGES    = 2,
   parameter int DEBOUNCE_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [DEBOUNCE_WIDTH-1:0] debounce_count,
   input  logic                      bypass,
   input  logic [GPIO_WIDTH-1:0]     gpio_pins_i,
   output logic [GPIO_WIDTH-1:0]     gpio_io_o,
   output logic [GPIO_WIDTH-1:0]     rise_o,
   output logic [GPIO_WIDTH-1:0]     fall_o
);
   for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_bit
      gpio_ic_bit #(
         .SYNC_STAGES   (SYNC_STAGES),
         .DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)
      ) u_bit (
         .clk     (clk),
         .rstn    (rstn),
         .pin_i   (gpio_pins_i[g]),
         .thresh_i(debounce_count),
         .bypass_i(bypass),
         .level_o (gpio_io_o[g]),
         .rise_o  (rise_o[g]),
         .fall_o  (fall_o[g])
      );
   end
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner: pin-delay/run-length reference model checked every
// cycle, plus directed scenarios with hand-computed edge timings.

module tb_gpio_input_conditioner;
   localparam int GW = 32;
   localparam int SS = 2;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          bypass = 1'b0;
   logic [DW-1:0] dcnt = '0;
   logic [GW-1:0] pins = '0;
   logic [GW-1:0] gpio_io, rise, fall;

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 1'b0;
   int rcnt[GW];
   int fcnt[GW];

   always #5 clk = ~clk;

   gpio_input_conditioner #(
      .GPIO_WIDTH(GW), .SYNC_STAGES(SS), .DEBOUNCE_WIDTH(DW)
   ) dut (
      .clk(clk), .rstn(rstn), .debounce_count(dcnt), .bypass(bypass),
      .gpio_pins_i(pins), .gpio_io_o(gpio_io), .rise_o(rise), .fall_o(fall)
   );

   task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference: the level seen by the debouncer is the pin value from SS edges ago;
   // a bit's output takes that level once it has disagreed for more than dcnt cycles.
   logic [GW-1:0] m_pipe[$];
   logic [GW-1:0] m_out, m_rise, m_fall, m_s, m_nxt;
   int            m_mis[GW];

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_pipe = {};
         for (int k = 0; k < SS; k++) m_pipe.push_back('0);
         m_out = '0; m_rise = '0; m_fall = '0;
         for (int i = 0; i < GW; i++) m_mis[i] = 0;
      end else begin
         m_s   = m_pipe.pop_front();
         m_pipe.push_back(pins);
         m_nxt = m_out;
         for (int i = 0; i < GW; i++) begin
            if (bypass) begin
               m_nxt[i] = m_s[i];
               m_mis[i] = 0;
            end else if (m_s[i] == m_out[i]) begin
               m_mis[i] = 0;
            end else if (m_mis[i] >= int'(dcnt)) begin
               m_nxt[i] = m_s[i];
               m_mis[i] = 0;
            end else begin
               m_mis[i] = m_mis[i] + 1;
            end
         end
         m_rise = ~m_out & m_nxt;
         m_fall = m_out & ~m_nxt;
         m_out  = m_nxt;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model gpio_io_o", gpio_io, m_out);
         check("model rise_o", rise, m_rise);
         check("model fall_o", fall, m_fall);
         check("rise_and_fall", rise & fall, '0);
      end
   end

   task automatic clr_cnt();
      for (int i = 0; i < GW; i++) begin rcnt[i] = 0; fcnt[i] = 0; end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         for (int i = 0; i < GW; i++) begin
            rcnt[i] += int'(rise[i]);
            fcnt[i] += int'(fall[i]);
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk); #2 rstn = 1'b0; pins = '0; bypass = 1'b0;
      repeat (2) @(negedge clk);
      #2 rstn = 1'b1;
   endtask

   logic [GW-1:0] okv;

   initial begin
      do_reset();
      chk_en = 1'b1;
      check("reset io", gpio_io, '0);
      check("reset rise", rise, '0);
      check("reset fall", fall, '0);

      // Clean step, threshold 3: new level at edge 2+3+1 = 6
      dcnt = DW'(3); clr_cnt();
      @(negedge clk); pins = 32'h1;
      run(5); check("t1 edge5 io", gpio_io, '0);
      run(1); check("t1 edge6 io", gpio_io, 32'h1);
      check("t1 edge6 rise", rise, 32'h1);
      check("t1 edge6 fall", fall, '0);
      run(1); check("t1 edge7 rise", rise, '0);
      run(4); check("t1 rise count", GW'(rcnt[0]), GW'(1));

      // Glitch rejection then accepted pulse, threshold 10
      do_reset(); dcnt = DW'(10); clr_cnt();
      @(negedge clk); pins = 32'h20;
      run(7); pins = '0;
      run(20); check("t2 glitch io", gpio_io, '0);
      check("t2 glitch rise count", GW'(rcnt[5]), '0);
      pins = 32'h20;
      run(12); check("t2 edge12 io", gpio_io, '0);
      pins = '0;
      run(1); check("t2 edge13 io", gpio_io, 32'h20);
      check("t2 edge13 rise", rise, 32'h20);
      run(11); check("t2 edge24 io", gpio_io, 32'h20);
      run(1); check("t2 edge25 io", gpio_io, '0);
      check("t2 edge25 fall", fall, 32'h20);
      run(3);
      check("t2 rise count", GW'(rcnt[5]), GW'(1));
      check("t2 fall count", GW'(fcnt[5]), GW'(1));

      // Bypass: 3-edge latency, one pulse per toggle
      do_reset(); bypass = 1'b1; dcnt = DW'(7); clr_cnt();
      @(negedge clk); pins[31] = 1'b1;
      run(2); check("t3 edge2 io", gpio_io, '0);
      run(1); check("t3 edge3 io", gpio_io, 32'h8000_0000);
      check("t3 edge3 rise", rise, 32'h8000_0000);
      run(1);
      for (int k = 0; k < 5; k++) begin
         pins[31] = ~pins[31];
         run(4);
      end
      run(4);
      check("t3 rise count", GW'(rcnt[31]), GW'(3));
      check("t3 fall count", GW'(fcnt[31]), GW'(3));
      check("t3 final io", gpio_io, '0);

      // Zero threshold, whole word at once
      do_reset(); dcnt = '0;
      @(negedge clk); pins = 32'hA5A5_A5A5;
      run(2); check("t4 edge2 io", gpio_io, '0);
      run(1); check("t4 edge3 io", gpio_io, 32'hA5A5_A5A5);
      check("t4 edge3 rise", rise, 32'hA5A5_A5A5);
      run(1); check("t4 edge4 rise", rise, '0);
      check("t4 edge4 io", gpio_io, 32'hA5A5_A5A5);

      // Threshold lowered mid-count: counter is 50 after edge 52
      do_reset(); dcnt = DW'(100);
      @(negedge clk); pins = 32'h4;
      run(52); check("t5 edge52 io", gpio_io, '0);
      dcnt = DW'(20);
      run(1); check("t5 edge53 io", gpio_io, 32'h4);
      check("t5 edge53 rise", rise, 32'h4);
      run(2);

      // Reset mid-count with all pins high
      dcnt = DW'(5); pins = '1;
      run(4); check("t6 pre-reset io", gpio_io, 32'h4);
      #2 rstn = 1'b0;
      #1 check("t6 async io", gpio_io, '0);
      check("t6 async rise", rise, '0);
      check("t6 async fall", fall, '0);
      @(negedge clk); #2 rstn = 1'b1;
      clr_cnt();
      run(7); check("t6 edge7 io", gpio_io, '0);
      run(1); check("t6 edge8 io", gpio_io, '1);
      check("t6 edge8 rise", rise, '1);
      run(3);
      for (int i = 0; i < GW; i++) okv[i] = (rcnt[i] == 1) && (fcnt[i] == 0);
      check("t6 one rise per bit", okv, '1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
